// File: rtl/store_pkg.sv
// Shared types and constants for the store merge unit.
package store_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } store_size_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } store_state_t;

  localparam int STORE_MAX_RD_LAT = 4;
  localparam int STORE_CNT_W = $clog2(STORE_MAX_RD_LAT);

  // The reserved encoding behaves as a word store.
  function automatic store_size_t norm_size(logic [1:0] s);
    return (s == 2'b11) ? WORD : store_size_t'(s);
  endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Big-endian lane merge of store data into a read word.
module store_lane_merge
  import store_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [31:0] merged
);

  store_size_t sz;

  assign sz = norm_size(size);

  always_comb begin
    merged = rdata;
    unique case (1'b1)
      (sz == BYTE): begin
        unique case (offset)
          2'd0: merged[31:24] = wdata[7:0];
          2'd1: merged[23:16] = wdata[7:0];
          2'd2: merged[15:8]  = wdata[7:0];
          2'd3: merged[7:0]   = wdata[7:0];
        endcase
      end
      (sz == HALF): begin
        if (offset[1])
          merged[15:0] = wdata[15:0];
        else
          merged[31:16] = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Multi-cycle store engine with read-modify-write for sub-word stores.
// Define STORE_ALIGN_CHECK_EN to enable misalignment detection.
module store_merge_unit
  import store_pkg::*;
#(
  parameter int MEM_RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [STORE_CNT_W-1:0] CNT_LAST =
    STORE_CNT_W'(MEM_RD_LAT - 1);

  store_state_t state;
  store_state_t state_nxt;
  store_size_t  size_in;
  store_size_t  size_q;

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rd_q;
  logic        err_q;
  logic        mis;
  logic        wait_last;
  logic [STORE_CNT_W-1:0] cnt;

  assign size_in = norm_size(size);
  assign wait_last = (cnt == CNT_LAST);

`ifdef STORE_ALIGN_CHECK_EN
  assign mis = ((size_in == HALF) && addr[0]) ||
               ((size_in == WORD) && (addr[1:0] != 2'b00));
`else
  assign mis = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (mis)
            state_nxt = DONE;
          else if (size_in == WORD)
            state_nxt = WRITE;
          else
            state_nxt = READ;
        end
      end
      READ:  state_nxt = WAIT;
      WAIT:  if (wait_last) state_nxt = WRITE;
      WRITE: state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size_q  <= BYTE;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && start) begin
        size_q  <= size_in;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= mis;
      end
      if (state == READ)
        cnt <= '0;
      else if (state == WAIT)
        cnt <= cnt + 1'b1;
      if (state == WAIT && wait_last)
        rd_q <= mem_rdata;
    end
  end

  store_lane_merge u_merge (
    .size   (size_q),
    .offset (addr_q[1:0]),
    .wdata  (wdata_q),
    .rdata  (rd_q),
    .merged (mem_wdata)
  );

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign err      = (state == DONE) && err_q;
  assign mem_rd   = (state == READ);
  assign mem_wr   = (state == WRITE);
  assign mem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_store_merge_unit.sv
// Scoreboard bench for store_merge_unit with a word-memory reference model.
module tb_store_merge_unit;

  localparam int LAT = 3;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  store_merge_unit #(.MEM_RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  wr_t wq[$];
  bit  eq[$];
  logic [31:0] mem_ref [int];

  function automatic logic [31:0] rd_word(int idx);
    if (!mem_ref.exists(idx))
      mem_ref[idx] = $urandom;
    return mem_ref[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    checks++;
    errors++;
    $display("FAIL %s actual=event required=none", nm);
  endtask

  // Memory read responder: data valid LAT cycles after the read strobe.
  initial begin
    bit pend;
    int due;
    int ridx;
    pend = 0;
    due = 0;
    ridx = 0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) pend = 0;
      if (pend) due--;
      if (mem_rd) begin
        pend = 1;
        due = LAT;
        ridx = int'(mem_addr[31:2]);
      end
      if (pend && due == 0) begin
        mem_rdata = rd_word(ridx);
        pend = 0;
      end else begin
        mem_rdata = $urandom;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT writes or completes.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (mem_rd) rd_seen++;
      if (mem_wr) begin
        wr_seen++;
        if (wq.size() == 0) begin
          flag("unexpected_wr");
        end else begin
          e = wq.pop_front();
          chk("wr_addr", mem_addr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          mem_ref[int'(e.addr[31:2])] = e.data;
        end
      end
      if (done) begin
        if (eq.size() == 0)
          flag("unexpected_done");
        else
          chk("err", {31'd0, err}, {31'd0, eq.pop_front()});
      end else if (rst_n) begin
        chk("err_idle", {31'd0, err}, 32'd0);
      end
    end
  end

  task automatic do_store(input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input int poke_at);
    bit mis;
    bit got;
    int explat;
    int sh;
    int n;
    int r0;
    int w0;
    logic [31:0] old;
    logic [31:0] mask;
    wr_t e;
    mis = 0;
`ifdef STORE_ALIGN_CHECK_EN
    if (sz == 2'b01 && a[0]) mis = 1;
    if (sz[1] && a[1:0] != 2'b00) mis = 1;
`endif
    n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy) flag("idle_timeout");
    e.addr = {a[31:2], 2'b00};
    if (mis) begin
      explat = 1;
    end else if (sz[1]) begin
      e.data = wd;
      wq.push_back(e);
      explat = 2;
    end else begin
      old = rd_word(int'(a[31:2]));
      if (sz == 2'b00) begin
        sh = (3 - int'(a[1:0])) * 8;
        mask = 32'hFF << sh;
      end else begin
        sh = a[1] ? 0 : 16;
        mask = 32'hFFFF << sh;
      end
      e.data = (old & ~mask) | ((wd << sh) & mask);
      wq.push_back(e);
      explat = 3 + LAT;
    end
    eq.push_back(mis);
    r0 = rd_seen;
    w0 = wr_seen;
    start = 1'b1;
    size = sz;
    addr = a;
    wdata = wd;
    @(negedge clk);
    start = 1'b0;
    size = 2'($urandom);
    addr = $urandom;
    wdata = $urandom;
    n = 1;
    got = 0;
    while (!got && n <= 20) begin
      chk("busy", {31'd0, busy}, 32'd1);
      if (done) begin
        got = 1;
      end else begin
        start = (n == poke_at);
        @(negedge clk);
        start = 1'b0;
        n++;
      end
    end
    if (!got) flag("done_timeout");
    else chk("latency", n, explat);
    chk("rd_count", rd_seen - r0, (!mis && !sz[1]) ? 1 : 0);
    chk("wr_count", wr_seen - w0, mis ? 0 : 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int r0;
    int w0;
    rst_n = 1'b0;
    start = 1'b0;
    size = 2'b00;
    addr = '0;
    wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_store(2'b10, 32'h100, 32'hDEADBEEF, 0);
    mem_ref[32'h102 >> 2] = 32'h11223344;
    do_store(2'b00, 32'h102, 32'h000000AB, 0);
    chk("byte_mem", mem_ref[32'h102 >> 2], 32'h1122AB44);
    mem_ref[32'h206 >> 2] = 32'hFFFFFFFF;
    do_store(2'b01, 32'h206, 32'h0000CAFE, 0);
    chk("half_mem", mem_ref[32'h206 >> 2], 32'hFFFFCAFE);
    do_store(2'b01, 32'h201, 32'h00001234, 0);
    do_store(2'b11, 32'h104, 32'h0BADF00D, 0);
    do_store(2'b00, 32'h107, 32'h55AA, 3);
    do_store(2'b10, 32'h108, 32'h13572468, 1);

    for (int i = 0; i < 150; i++)
      do_store(2'($urandom), 32'h100 + 32'($urandom_range(0, 63)),
               $urandom, int'($urandom_range(0, 5)));

    while (busy) @(negedge clk);
    @(negedge clk);
    r0 = rd_seen;
    w0 = wr_seen;
    size = 2'b10;
    addr = 32'h140;
    wdata = 32'hA5A5A5A5;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("pre_rst_wr", {31'd0, mem_wr}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", {31'd0, mem_wr}, 32'd0);
    chk("rst_busy_drop", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    chk("post_rst_rd", rd_seen - r0, 0);
    chk("post_rst_wr", wr_seen - w0, 0);
    chk("wq_empty", wq.size(), 0);
    chk("eq_empty", eq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
